// File: rtl/apb_master_pkg.sv
// Shared state encoding and default address map for the APB initiator.
// Imported by the decoder and the initiator top.
package apb_master_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2,
        StResp   = 2'd3
    } state_e;

    localparam logic [31:0] PERIPH_BASE = 32'h1000_0000;
    localparam logic [31:0] PERIPH_MASK = 32'hFFFF_0000;
    localparam logic [31:0] TIMER_BASE  = 32'h1100_0000;
    localparam logic [31:0] TIMER_MASK  = 32'hFFFF_0000;

    // A disabled timeout (0) still needs a one-bit counter to keep the logic legal.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_master_if.sv
// CPU request/response port and APB segment signals of the initiator.
// The master modport is the initiator's view; slave is the CPU plus responders.
interface apb_master_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_SLAVES = 2
);

    logic                           req_valid;
    logic                           req_ready;
    logic [ADDR_WIDTH-1:0]          req_addr;
    logic [DATA_WIDTH-1:0]          req_wdata;
    logic [3:0]                     req_wstrb;
    logic                           req_write;

    logic                           resp_valid;
    logic [DATA_WIDTH-1:0]          resp_rdata;
    logic                           resp_err;

    logic [ADDR_WIDTH-1:0]          paddr;
    logic [DATA_WIDTH-1:0]          pdata;
    logic                           pwrite;
    logic [3:0]                     pstb;
    logic [NUM_SLAVES-1:0]          psel;
    logic                           penable;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata;
    logic [NUM_SLAVES-1:0]          pready;
    logic [NUM_SLAVES-1:0]          perr;

    modport master (
        input  req_valid, req_addr, req_wdata, req_wstrb, req_write,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output paddr, pdata, pwrite, pstb, psel, penable,
        input  prdata, pready, perr
    );

    modport slave (
        output req_valid, req_addr, req_wdata, req_wstrb, req_write,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  paddr, pdata, pwrite, pstb, psel, penable,
        output prdata, pready, perr
    );

endinterface

// File: rtl/apb_decode.sv
// Combinational address decoder: one-hot region hit plus miss flag.
// Lowest slave index wins when regions overlap.
module apb_decode #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned NUM_SLAVES = 2,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [NUM_SLAVES-1:0] hit,
    output logic                  miss
);

    logic found;

    always_comb begin
        hit   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!found &&
                ((addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                 SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                hit[i] = 1'b1;
                found  = 1'b1;
            end
        end
        miss = ~found;
    end

endmodule

// File: rtl/apb_master.sv
// APB initiator: takes one CPU request at a time, runs SETUP/ACCESS against the
// decoded responder and returns a one-cycle response pulse with data and error.
module apb_master
    import apb_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_SLAVES     = 2,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {TIMER_BASE, PERIPH_BASE},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {TIMER_MASK, PERIPH_MASK},
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic          APB_PCLK,
    input  logic          APB_PRESET,
    apb_master_if.master  bus
);

    localparam int unsigned CntW = cnt_width(TIMEOUT_CYCLES);

    state_e                state_q;
    logic [CntW-1:0]       cnt_q;

    logic [NUM_SLAVES-1:0] hit;
    logic                  miss;

    logic                  sel_ready;
    logic                  sel_err;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                  timed_out;

    apb_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decode (
        .addr (bus.req_addr),
        .hit  (hit),
        .miss (miss)
    );

    // psel is one-hot while a transfer is live, so it masks out every other responder.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (bus.psel[i]) begin
                sel_ready = sel_ready | bus.pready[i];
                sel_err   = sel_err | bus.perr[i];
                sel_rdata = sel_rdata | bus.prdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Fires on the edge that closes the TIMEOUT_CYCLES-th ACCESS cycle.
    assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge APB_PCLK or posedge APB_PRESET) begin
        if (APB_PRESET) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            bus.req_ready  <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
            bus.paddr      <= '0;
            bus.pdata      <= '0;
            bus.pwrite     <= 1'b0;
            bus.pstb       <= '0;
            bus.psel       <= '0;
            bus.penable    <= 1'b0;
        end else begin
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (bus.req_ready && bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        bus.paddr     <= bus.req_addr;
                        bus.pwrite    <= bus.req_write;
                        bus.pdata     <= bus.req_write ? bus.req_wdata : '0;
                        bus.pstb      <= bus.req_write ? bus.req_wstrb : 4'h0;
                        if (miss) begin
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            state_q        <= StResp;
                        end else begin
                            bus.psel <= hit;
                            state_q  <= StSetup;
                        end
                    end else begin
                        bus.req_ready <= 1'b1;
                    end
                end

                StSetup: begin
                    bus.penable <= 1'b1;
                    cnt_q       <= '0;
                    state_q     <= StAccess;
                end

                StAccess: begin
                    // pready wins over a timeout landing on the same edge.
                    if (sel_ready) begin
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= sel_err;
                        bus.resp_rdata <= (!bus.pwrite && !sel_err) ? sel_rdata : '0;
                        bus.psel       <= '0;
                        bus.penable    <= 1'b0;
                        state_q        <= StResp;
                    end else if (timed_out) begin
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b1;
                        bus.psel       <= '0;
                        bus.penable    <= 1'b0;
                        state_q        <= StResp;
                    end else if (cnt_q != {CntW{1'b1}}) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StResp: begin
                    bus.req_ready <= 1'b1;
                    state_q       <= StIdle;
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: a per-cycle timeline model built from the
// request/responder scenario, a compare process, and literal pins per scenario.
module tb_apb_master;

    localparam int TMO  = 4;
    localparam int NS   = 2;
    localparam int MAXC = 1024;

    logic clk;
    logic rst;

    apb_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(NS)) bus ();

    apb_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .NUM_SLAVES     (NS),
        .SLAVE_BASE     ({32'h1100_0000, 32'h1000_0000}),
        .SLAVE_MASK     ({32'hFFFF_0000, 32'hFFFF_0000}),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .APB_PCLK   (clk),
        .APB_PRESET (rst),
        .bus        (bus)
    );

    logic [31:0] base [NS] = '{32'h1000_0000, 32'h1100_0000};
    logic [31:0] mask [NS] = '{32'hFFFF_0000, 32'hFFFF_0000};

    // Expected timeline, indexed by cycle number (cycle k follows clock edge k).
    logic [1:0]  e_psel   [MAXC];
    bit          e_pen    [MAXC];
    bit          e_rv     [MAXC];
    bit          e_ready  [MAXC];
    bit          e_err    [MAXC];
    bit          e_bus    [MAXC];
    bit          e_pwrite [MAXC];
    logic [31:0] e_rd     [MAXC];
    logic [31:0] e_paddr  [MAXC];
    logic [31:0] e_pdata  [MAXC];
    logic [3:0]  e_pstb   [MAXC];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit chk_en = 0;

    int          n_sel, n_en, n_rv;
    logic [1:0]  obs_psel;
    logic [31:0] obs_pdata, last_rd;
    logic [3:0]  obs_pstb;
    logic        obs_pwrite, last_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_from(input int c);
        for (int i = c; i < MAXC; i++) begin
            e_psel[i] = 2'b00; e_pen[i] = 0; e_rv[i] = 0; e_ready[i] = 1; e_err[i] = 0;
            e_bus[i] = 0; e_pwrite[i] = 0; e_rd[i] = '0; e_paddr[i] = '0;
            e_pdata[i] = '0; e_pstb[i] = '0;
        end
    endtask

    always @(negedge clk) begin
        if (bus.psel != 2'b00) begin n_sel++; obs_psel = bus.psel; end
        if (bus.penable) begin
            n_en++; obs_pdata = bus.pdata; obs_pstb = bus.pstb; obs_pwrite = bus.pwrite;
        end
        if (bus.resp_valid) begin n_rv++; last_rd = bus.resp_rdata; last_err = bus.resp_err; end
        if (chk_en && cyc < MAXC) begin
            check("psel", 32'(bus.psel), 32'(e_psel[cyc]));
            check("penable", 32'(bus.penable), 32'(e_pen[cyc]));
            check("resp_valid", 32'(bus.resp_valid), 32'(e_rv[cyc]));
            check("req_ready", 32'(bus.req_ready), 32'(e_ready[cyc]));
            if (e_bus[cyc]) begin
                check("paddr", bus.paddr, e_paddr[cyc]);
                check("pdata", bus.pdata, e_pdata[cyc]);
                check("pwrite", 32'(bus.pwrite), 32'(e_pwrite[cyc]));
                check("pstb", 32'(bus.pstb), 32'(e_pstb[cyc]));
            end
            if (e_rv[cyc]) begin
                check("resp_rdata", bus.resp_rdata, e_rd[cyc]);
                check("resp_err", 32'(bus.resp_err), 32'(e_err[cyc]));
            end
        end
    end

    task automatic send_req(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                            input logic [3:0] ws, output int c0, output bit ok);
        int g = 0;
        ok = 0;
        c0 = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_write = wr;
        bus.req_wdata = wd;
        bus.req_wstrb = ws;
        while (g < 50 && !ok) begin
            @(negedge clk);
            g++;
            if (bus.req_ready === 1'b1) ok = 1;
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_wait: req_ready still %b after 50 cycles, expected 1",
                     bus.req_ready);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        c0 = cyc;
        bus.req_valid = 1'b0;
    endtask

    task automatic txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input logic [3:0] ws, input int waits, input logic serr,
                       input logic [31:0] srd);
        int  c0, hit, n, rc;
        bit  ok, tmo;
        logic err;
        hit = -1;
        for (int s = 0; s < NS; s++)
            if (hit < 0 && ((addr & mask[s]) == base[s])) hit = s;
        n_sel = 0; n_en = 0; n_rv = 0;
        send_req(addr, wr, wd, ws, c0, ok);
        if (!ok) return;
        if (hit < 0) begin
            e_rv[c0] = 1; e_err[c0] = 1; e_rd[c0] = '0; e_ready[c0] = 0;
            @(posedge clk); #1;
        end else begin
            tmo = (waits >= TMO);
            n   = tmo ? TMO : waits + 1;
            err = tmo | serr;
            rc  = c0 + n + 1;
            for (int c = c0; c <= rc; c++) begin
                e_ready[c] = 0; e_bus[c] = 1; e_paddr[c] = addr; e_pwrite[c] = wr;
                e_pdata[c] = wr ? wd : 32'h0; e_pstb[c] = wr ? ws : 4'h0;
            end
            for (int c = c0; c < rc; c++) begin
                e_psel[c] = 2'(1 << hit);
                e_pen[c]  = (c > c0);
            end
            e_rv[rc] = 1; e_err[rc] = err; e_rd[rc] = (wr || err) ? 32'h0 : srd;
            // The unselected responder shouts ready/error/junk; none of it may leak.
            bus.pready[1-hit] = 1'b1;
            bus.perr[1-hit]   = 1'b1;
            bus.prdata[(1-hit)*32 +: 32] = 32'hBAD0_BAD0;
            bus.prdata[hit*32 +: 32]     = srd;
            for (int j = 0; j < n; j++) begin
                @(posedge clk); #1;
                bus.pready[hit] = (j == waits);
                bus.perr[hit]   = (j == waits) && serr;
            end
            @(posedge clk); #1;
            bus.pready = '0; bus.perr = '0; bus.prdata = '0;
            @(posedge clk); #1;
        end
    endtask

    task automatic pins(input string tag, input int sel, input int en,
                        input logic [31:0] rd, input logic err);
        check({tag, ".sel_cycles"}, n_sel, sel);
        check({tag, ".en_cycles"}, n_en, en);
        check({tag, ".resp_count"}, n_rv, 1);
        check({tag, ".rdata"}, last_rd, rd);
        check({tag, ".err"}, 32'(last_err), 32'(err));
    endtask

    initial begin
        int  c0;
        bit  ok;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.req_wstrb = '0; bus.req_write = 1'b0;
        bus.prdata = '0; bus.pready = '0; bus.perr = '0;
        clear_from(0);

        #3;
        check("rst.psel", 32'(bus.psel), 0);
        check("rst.penable", 32'(bus.penable), 0);
        check("rst.req_ready", 32'(bus.req_ready), 0);
        check("rst.resp_valid", 32'(bus.resp_valid), 0);
        check("rst.paddr", bus.paddr, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check("release.ready_before_edge", 32'(bus.req_ready), 0);
        @(posedge clk); #1;
        check("release.ready_first_cycle", 32'(bus.req_ready), 1);
        chk_en = 1;

        // Timer read, one wait state.
        txn(32'h1100_BFF8, 1'b0, 32'h0, 4'h0, 1, 1'b0, 32'h0000_1234);
        pins("rd_timer", 3, 2, 32'h0000_1234, 1'b0);
        check("rd_timer.psel_value", 32'(obs_psel), 32'h2);

        // Full-word write to the timer.
        txn(32'h1100_4000, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0);
        pins("wr_timer", 2, 1, 32'h0, 1'b0);
        check("wr_timer.pdata", obs_pdata, 32'hDEAD_BEEF);
        check("wr_timer.pstb", 32'(obs_pstb), 32'hF);
        check("wr_timer.pwrite", 32'(obs_pwrite), 1);

        // Unmapped read.
        txn(32'h2000_0000, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h0);
        pins("miss", 0, 0, 32'h0, 1'b1);

        // Responder never ready: timeout after exactly TMO ACCESS cycles.
        txn(32'h1100_0010, 1'b0, 32'h0, 4'h0, 99, 1'b0, 32'h7777_7777);
        pins("timeout", 5, 4, 32'h0, 1'b1);

        // Next request after a timeout, on slave 0.
        txn(32'h1000_0010, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'hCAFE_0001);
        pins("rd_s0", 2, 1, 32'hCAFE_0001, 1'b0);
        check("rd_s0.psel_value", 32'(obs_psel), 32'h1);

        // Responder error.
        txn(32'h1000_0020, 1'b0, 32'h0, 4'h0, 2, 1'b1, 32'h0000_0055);
        pins("perr", 4, 3, 32'h0, 1'b1);

        // pready on the timeout edge counts as success.
        txn(32'h1100_0030, 1'b0, 32'h0, 4'h0, 3, 1'b0, 32'h00C0_FFEE);
        pins("coincide", 5, 4, 32'h00C0_FFEE, 1'b0);

        // Partial-strobe write to slave 0.
        txn(32'h1000_0104, 1'b1, 32'h1234_5678, 4'h3, 1, 1'b0, 32'h0);
        pins("wr_s0", 3, 2, 32'h0, 1'b0);
        check("wr_s0.pstb", 32'(obs_pstb), 32'h3);

        // Reset during ACCESS aborts with no response.
        chk_en = 0;
        n_rv = 0;
        send_req(32'h1100_0020, 1'b0, 32'h0, 4'h0, c0, ok);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort.in_access_psel", 32'(bus.psel), 32'h2);
        check("abort.in_access_penable", 32'(bus.penable), 1);
        #2 rst = 1'b1;
        #1;
        check("abort.psel", 32'(bus.psel), 0);
        check("abort.penable", 32'(bus.penable), 0);
        check("abort.req_ready", 32'(bus.req_ready), 0);
        check("abort.resp_valid", 32'(bus.resp_valid), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort.no_resp", n_rv, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort.ready_after_release", 32'(bus.req_ready), 1);
        clear_from(cyc);
        chk_en = 1;
        txn(32'h1100_0040, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h0000_ABCD);
        pins("after_abort", 2, 1, 32'h0000_ABCD, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
